// File: rtl/rv_plic_claim_sequencer.sv
// Hardware claim/complete engine for one PLIC target context: claims via CC read,
// hands the ID to a non-CPU handler, then completes via CC write.
module rv_plic_claim_sequencer #(
  parameter int          SrcW          = 6,
  parameter logic [31:0] CcAddr        = 32'h0020_0004,
  parameter int          HoldoffCycles = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            irq_i,
  output logic            req_o,
  output logic            we_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
  input  logic            gnt_i,
  input  logic            rvalid_i,
  input  logic [31:0]     rdata_i,
  input  logic            err_i,
  output logic            dispatch_valid_o,
  output logic [SrcW-1:0] dispatch_id_o,
  input  logic            dispatch_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            spurious_o,
  output logic            err_o,
  output logic [15:0]     claim_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, CLAIM_REQ, CLAIM_RSP, DISPATCH, SERVICE, COMPLETE_REQ, COMPLETE_RSP, HOLDOFF
  } state_e;

  state_e      state;
  logic [7:0]  hold_cnt;
  logic [15:0] cnt_q;

  // Upper read-data bits carry nothing for an ID of SrcW bits.
  logic unused_rdata;
  assign unused_rdata = ^rdata_i[31:SrcW];

  assign claim_cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      cnt_q            <= '0;
      req_o            <= 1'b0;
      we_o             <= 1'b0;
      addr_o           <= '0;
      wdata_o          <= '0;
      dispatch_valid_o <= 1'b0;
      dispatch_id_o    <= '0;
      busy_o           <= 1'b0;
      spurious_o       <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      spurious_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en_i && irq_i) begin
            state   <= CLAIM_REQ;
            req_o   <= 1'b1;
            we_o    <= 1'b0;
            addr_o  <= CcAddr;
            wdata_o <= '0;
            busy_o  <= 1'b1;
          end
        end
        CLAIM_REQ: begin
          if (gnt_i) begin
            state  <= CLAIM_RSP;
            req_o  <= 1'b0;
            addr_o <= '0;
          end
        end
        CLAIM_RSP: begin
          if (rvalid_i) begin
            if (err_i) begin
              err_o    <= 1'b1;
              state    <= HOLDOFF;
              hold_cnt <= 8'(HoldoffCycles);
            end else if (rdata_i[SrcW-1:0] == '0) begin
              spurious_o <= 1'b1;
              state      <= HOLDOFF;
              hold_cnt   <= 8'(HoldoffCycles);
            end else begin
              dispatch_id_o    <= rdata_i[SrcW-1:0];
              dispatch_valid_o <= 1'b1;
              state            <= DISPATCH;
            end
          end
        end
        DISPATCH: begin
          if (dispatch_ready_i) begin
            dispatch_valid_o <= 1'b0;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (done_i) begin
            state   <= COMPLETE_REQ;
            req_o   <= 1'b1;
            we_o    <= 1'b1;
            addr_o  <= CcAddr;
            wdata_o <= {{(32-SrcW){1'b0}}, dispatch_id_o};
          end
        end
        COMPLETE_REQ: begin
          if (gnt_i) begin
            state   <= COMPLETE_RSP;
            req_o   <= 1'b0;
            we_o    <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
          end
        end
        COMPLETE_RSP: begin
          if (rvalid_i) begin
            if (err_i) err_o <= 1'b1;
            state    <= HOLDOFF;
            hold_cnt <= 8'(HoldoffCycles);
          end
        end
        HOLDOFF: begin
          // Gives the gateway and target time to drop irq for the serviced source.
          hold_cnt <= hold_cnt - 8'd1;
          if (hold_cnt <= 8'd1) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // A response may not arrive in the same cycle its request is granted.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(req_o && gnt_i && rvalid_i))
    else $error("response in grant cycle");

endmodule

// File: tb/tb_rv_plic_claim_sequencer.sv
// Directed bench for rv_plic_claim_sequencer with a 1-outstanding bus responder.
module tb_rv_plic_claim_sequencer;
  localparam int          SrcW   = 6;
  localparam logic [31:0] CcAddr = 32'h0020_0004;

  logic clk = 1'b0, rst_ni = 1'b0, en_i = 1'b0, irq_i = 1'b0;
  logic gnt_i = 1'b0, rvalid_i = 1'b0, err_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic dispatch_ready_i = 1'b0, done_i = 1'b0;
  logic req_o, we_o, dispatch_valid_o, busy_o, spurious_o, err_o;
  logic [31:0] addr_o, wdata_o;
  logic [SrcW-1:0] dispatch_id_o;
  logic [15:0] claim_cnt_o;

  rv_plic_claim_sequencer #(.SrcW(SrcW), .CcAddr(CcAddr), .HoldoffCycles(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .irq_i(irq_i),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .dispatch_valid_o(dispatch_valid_o), .dispatch_id_o(dispatch_id_o),
    .dispatch_ready_i(dispatch_ready_i), .done_i(done_i),
    .busy_o(busy_o), .spurious_o(spurious_o), .err_o(err_o), .claim_cnt_o(claim_cnt_o)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;

  // Responder configuration, driven by the main sequence
  int gnt_delay = 0;
  logic [31:0] rd_data = '0;
  logic rd_err = 1'b0, wr_err = 1'b0;

  // Responder/monitor state
  int wait_cnt = 0, nrd = 0, nwr = 0, ndisp = 0, nspur = 0;
  int busy_cyc = 0, req_cyc = 0, dv_cyc = 0, unstable = 0;
  int cyc_no = 0, last_rise = 0, rise_gap = 0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, prev_addr = '0, prev_wdata = '0;
  logic [SrcW-1:0] last_id = '0;
  logic last_we = 1'b0, prev_req = 1'b0, prev_we = 1'b0;

  // Acts 2ns after each edge: observes outputs and drives the bus inputs.
  initial forever begin
    @(posedge clk); #2;
    cyc_no++;
    if (busy_o) busy_cyc++;
    if (req_o) req_cyc++;
    if (dispatch_valid_o) dv_cyc++;
    if (spurious_o) nspur++;
    if (dispatch_valid_o && dispatch_ready_i) begin ndisp++; last_id = dispatch_id_o; end
    if (req_o && prev_req && (we_o !== prev_we || addr_o !== prev_addr || wdata_o !== prev_wdata))
      unstable++;
    if (req_o && !prev_req) begin rise_gap = cyc_no - last_rise; last_rise = cyc_no; end
    prev_req = req_o; prev_we = we_o; prev_addr = addr_o; prev_wdata = wdata_o;
    rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
    if (gnt_i) begin
      gnt_i = 1'b0; rvalid_i = 1'b1;
      if (last_we) err_i = wr_err;
      else begin rdata_i = rd_data; err_i = rd_err; end
    end else if (!req_o) begin
      wait_cnt = 0;
    end else if (wait_cnt >= gnt_delay) begin
      gnt_i = 1'b1; wait_cnt = 0; last_we = we_o;
      if (we_o) begin nwr++; wr_addr = addr_o; wr_data = wdata_o; end
      else begin nrd++; rd_addr = addr_o; end
    end else begin
      wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq();
    irq_i = 1'b1; cyc(1); irq_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy_o && k < 200) begin cyc(1); k++; end
    chk(tag, 32'(busy_o), 0);
  endtask

  int b_rd, b_wr, b_disp, b_spur, b_busy, b_req, b_dv, b_unst, idbad, k;

  task automatic snap();
    b_rd = nrd; b_wr = nwr; b_disp = ndisp; b_spur = nspur;
    b_busy = busy_cyc; b_req = req_cyc; b_dv = dv_cyc; b_unst = unstable;
  endtask

  initial begin
    cyc(2);
    chk("rst_req_we", {30'd0, req_o, we_o}, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_flags", {28'd0, dispatch_valid_o, busy_o, spurious_o, err_o}, 0);
    chk("rst_id_cnt", {10'd0, dispatch_id_o, claim_cnt_o}, 0);
    rst_ni = 1'b1; en_i = 1'b1; dispatch_ready_i = 1'b1; done_i = 1'b1;
    cyc(2);

    // Basic flow, zero-wait everything
    rd_data = 32'h0000_0005; snap();
    pulse_irq(); wait_idle("basic_idle");
    chk("basic_reads", nrd - b_rd, 1);
    chk("basic_writes", nwr - b_wr, 1);
    chk("basic_rd_addr", rd_addr, CcAddr);
    chk("basic_wr_addr", wr_addr, CcAddr);
    chk("basic_wdata", wr_data, 5);
    chk("basic_id", 32'(last_id), 5);
    chk("basic_cnt", 32'(claim_cnt_o), 1);
    chk("basic_busy_cycles", busy_cyc - b_busy, 10);
    chk("basic_no_spur", nspur - b_spur, 0);

    // Spurious claim
    rd_data = 32'h0; snap();
    pulse_irq(); wait_idle("spur_idle");
    chk("spur_pulse", nspur - b_spur, 1);
    chk("spur_no_dv", dv_cyc - b_dv, 0);
    chk("spur_no_write", nwr - b_wr, 0);
    chk("spur_reads", nrd - b_rd, 1);
    chk("spur_cnt", 32'(claim_cnt_o), 1);
    chk("spur_busy_cycles", busy_cyc - b_busy, 6);

    // Backpressure: grant after 3 waits, handler ready after 5 cycles; high ID bits ignored
    gnt_delay = 3; dispatch_ready_i = 1'b0; rd_data = 32'hABCD_EF09; snap();
    pulse_irq();
    k = 0;
    while (!dispatch_valid_o && k < 100) begin cyc(1); k++; end
    chk("bp_dv_seen", 32'(dispatch_valid_o), 1);
    idbad = 0;
    repeat (5) begin
      if (dispatch_id_o !== 6'd9 || !dispatch_valid_o) idbad++;
      cyc(1);
    end
    chk("bp_id_stable", idbad, 0);
    dispatch_ready_i = 1'b1;
    wait_idle("bp_idle");
    chk("bp_bus_stable", unstable - b_unst, 0);
    chk("bp_req_cycles", req_cyc - b_req, 8);
    chk("bp_dv_cycles", dv_cyc - b_dv, 6);
    chk("bp_reads_writes", ((nrd - b_rd) << 8) | (nwr - b_wr), 32'h101);
    chk("bp_id", 32'(last_id), 9);
    chk("bp_wdata", wr_data, 9);
    chk("bp_cnt", 32'(claim_cnt_o), 2);
    gnt_delay = 0;

    // Bus error on claim, then a normal claim of ID 3
    rd_err = 1'b1; rd_data = 32'h5; snap();
    pulse_irq(); wait_idle("err_idle");
    chk("err_set", 32'(err_o), 1);
    chk("err_no_dv", dv_cyc - b_dv, 0);
    chk("err_no_write", nwr - b_wr, 0);
    rd_err = 1'b0; rd_data = 32'h3;
    pulse_irq(); wait_idle("err_next_idle");
    chk("err_next_id", 32'(last_id), 3);
    chk("err_next_wdata", wr_data, 3);
    chk("err_sticky", 32'(err_o), 1);
    chk("err_next_cnt", 32'(claim_cnt_o), 3);

    // Enable gating, enable dropped during service, holdoff with irq held
    en_i = 1'b0; irq_i = 1'b1; snap();
    cyc(5);
    chk("en_off_no_req", req_cyc - b_req, 0);
    chk("en_off_idle", 32'(busy_o), 0);
    rd_data = 32'h7; done_i = 1'b0; en_i = 1'b1;
    k = 0;
    while (ndisp == b_disp && k < 100) begin cyc(1); k++; end
    chk("svc_dispatched", ndisp - b_disp, 1);
    en_i = 1'b0;
    cyc(3);
    done_i = 1'b1;
    wait_idle("svc_idle");
    chk("svc_write", nwr - b_wr, 1);
    chk("svc_wdata", wr_data, 7);
    cyc(4);
    chk("svc_no_reclaim", nrd - b_rd, 1);
    b_rd = nrd; en_i = 1'b1;
    k = 0;
    while (nrd - b_rd < 2 && k < 100) begin cyc(1); k++; end
    chk("hold_gap", rise_gap, 7);
    irq_i = 1'b0;
    wait_idle("hold_idle");

    // Asynchronous reset while the completion write is pending
    gnt_delay = 3; rd_data = 32'h4;
    pulse_irq();
    k = 0;
    while (!(req_o && we_o) && k < 100) begin cyc(1); k++; end
    chk("mid_reached", 32'(req_o & we_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_req_we", {30'd0, req_o, we_o}, 0);
    chk("mid_addr_wdata", addr_o | wdata_o, 0);
    chk("mid_flags", {28'd0, dispatch_valid_o, busy_o, spurious_o, err_o}, 0);
    chk("mid_id_cnt", {10'd0, dispatch_id_o, claim_cnt_o}, 0);
    cyc(2);
    rst_ni = 1'b1; gnt_delay = 0;
    cyc(2);

    // Counter saturation from a preloaded near-full value
    force dut.cnt_q = 16'hFFFE;
    cyc(1);
    release dut.cnt_q;
    chk("sat_preload", 32'(claim_cnt_o), 32'hFFFE);
    rd_data = 32'h2; snap();
    pulse_irq(); wait_idle("sat_idle1");
    chk("sat_reach", 32'(claim_cnt_o), 32'hFFFF);
    pulse_irq(); wait_idle("sat_idle2");
    chk("sat_hold", 32'(claim_cnt_o), 32'hFFFF);
    chk("sat_dispatches", ndisp - b_disp, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
